// File: rtl/mod_instruction_fetch_ctrl.sv
// Instruction fetch controller: holds the PC, drives the ROM address and buffers each fetched
// word in a one-entry valid/ready output register, with redirect and end-of-program halt.
module mod_instruction_fetch_ctrl #(
    parameter logic [29:0] START_ADDR = 30'd0,
    parameter int          COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [29:0]        rom_address,
    input  logic [31:0]        rom_instruction,
    input  logic               rom_mem_end,
    output logic [31:0]        instr_out,
    output logic [29:0]        instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [29:0]        redirect_addr,
    output logic               halted,
    output logic [COUNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t               state_q, state_d;
    logic [29:0]          pc_q, pc_d;
    logic [31:0]          instr_out_q, instr_out_d;
    logic [29:0]          instr_pc_q, instr_pc_d;
    logic                 instr_valid_q, instr_valid_d;
    logic                 halted_q, halted_d;
    logic [COUNT_W-1:0]   fetch_count_q, fetch_count_d;
    logic                 slot_free;

    assign slot_free = !instr_valid_q || instr_ready;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_out_d   = instr_out_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = START_ADDR;
                end
            end
            ST_RUN, ST_HALT: begin
                // A redirect flushes the buffer even if the consumer took the word this cycle.
                if (redirect_valid) begin
                    state_d       = ST_RUN;
                    pc_d          = redirect_addr;
                    instr_valid_d = 1'b0;
                    halted_d      = 1'b0;
                end else if (state_q == ST_HALT) begin
                    if (instr_ready) begin
                        instr_valid_d = 1'b0;
                    end
                end else if (rom_mem_end) begin
                    // A stalled word stays visible in HALT until the consumer accepts it.
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                    if (instr_ready) begin
                        instr_valid_d = 1'b0;
                    end
                end else if (slot_free) begin
                    instr_out_d   = rom_instruction;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + 30'd1;
                    fetch_count_d = fetch_count_q + COUNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= START_ADDR;
            instr_out_q   <= 32'd0;
            instr_pc_q    <= 30'd0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_out_q   <= instr_out_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign rom_address = pc_q;
    assign instr_out   = instr_out_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_mod_instruction_fetch_ctrl.sv
// Self-checking bench for mod_instruction_fetch_ctrl: directed scenarios on a tiny ROM, a
// wrap-around instance, and a randomized run against a behavioural fetch model.
module tb_mod_instruction_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, instr_ready, redirect_valid;
    logic [29:0] redirect_addr;
    logic        rom_mode;
    int          tests_run = 0;
    int          tests_failed = 0;

    logic [29:0] rom_address0, instr_pc0;
    logic [31:0] rom_instruction0, instr_out0;
    logic        rom_mem_end0, instr_valid0, halted0;
    logic [15:0] fetch_count0;

    logic [29:0] rom_address1, instr_pc1;
    logic [31:0] rom_instruction1, instr_out1;
    logic        instr_valid1, halted1;
    logic [15:0] fetch_count1;
    logic        rom_mem_end1 = 1'b0;
    logic        redirect_valid1 = 1'b0;
    logic [29:0] redirect_addr1 = 30'd0;

    // Behavioural model state
    logic        m_running, m_halted, m_valid;
    logic [29:0] m_pc, m_ipc;
    logic [31:0] m_out;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    mod_instruction_fetch_ctrl #(.START_ADDR(30'd0), .COUNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .start(start),
        .rom_address(rom_address0), .rom_instruction(rom_instruction0), .rom_mem_end(rom_mem_end0),
        .instr_out(instr_out0), .instr_pc(instr_pc0), .instr_valid(instr_valid0),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .halted(halted0), .fetch_count(fetch_count0)
    );

    mod_instruction_fetch_ctrl #(.START_ADDR(30'h3FFFFFFF), .COUNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .start(start),
        .rom_address(rom_address1), .rom_instruction(rom_instruction1), .rom_mem_end(rom_mem_end1),
        .instr_out(instr_out1), .instr_pc(instr_pc1), .instr_valid(instr_valid1),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid1), .redirect_addr(redirect_addr1),
        .halted(halted1), .fetch_count(fetch_count1)
    );

    function automatic logic [31:0] romInstr(input logic mode, input logic [29:0] a);
        if (!mode) return (a == 30'd0) ? 32'h2001000D : 32'd0;
        return 32'h9E3779B9 * {2'b00, a} + 32'h00001234;
    endfunction

    function automatic logic romEnd(input logic mode, input logic [29:0] a);
        if (!mode) return a > 30'd0;
        return a >= 30'd20;
    endfunction

    assign rom_instruction0 = romInstr(rom_mode, rom_address0);
    assign rom_mem_end0     = romEnd(rom_mode, rom_address0);
    assign rom_instruction1 = {2'b00, rom_address1} ^ 32'hA5A50000;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        reset = 1'b1; start = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_addr = 30'd0;
        stepClock();
        reset = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelStep();
        logic [29:0] a;
        a = m_pc;
        if (reset) begin
            m_running = 0; m_halted = 0; m_pc = 30'd0; m_valid = 0;
            m_out = 32'd0; m_ipc = 30'd0; m_cnt = 16'd0;
        end else if (!m_running && !m_halted) begin
            if (start) begin m_running = 1; m_pc = 30'd0; end
        end else if (redirect_valid) begin
            m_running = 1; m_halted = 0; m_pc = redirect_addr; m_valid = 0;
        end else if (m_halted || romEnd(1'b1, a)) begin
            m_running = 0; m_halted = 1;
            if (instr_ready) m_valid = 0;
        end else if (!m_valid || instr_ready) begin
            m_out = romInstr(1'b1, a); m_ipc = a; m_valid = 1;
            m_pc = a + 30'd1; m_cnt = m_cnt + 16'd1;
        end
    endtask

    task automatic applyStimulus();
        int r;
        r = $urandom_range(0, 99);
        reset          = (r == 0);
        start          = ($urandom_range(0, 9) == 0);
        instr_ready    = ($urandom_range(0, 9) < 7);
        redirect_valid = ($urandom_range(0, 19) == 0);
        redirect_addr  = 30'($urandom_range(0, 25));
    endtask

    initial begin
        rom_mode = 1'b0;

        // Reset values and the basic fetch-then-halt sequence
        resetDut();
        checkOutput("rst_valid", {63'd0, instr_valid0}, 64'd0);
        checkOutput("rst_halted", {63'd0, halted0}, 64'd0);
        checkOutput("rst_count", {48'd0, fetch_count0}, 64'd0);
        checkOutput("rst_out", {32'd0, instr_out0}, 64'd0);
        checkOutput("rst_addr", {34'd0, rom_address0}, 64'd0);
        start = 1'b1; instr_ready = 1'b1;
        stepClock();
        start = 1'b0;
        checkOutput("t1_run_valid", {63'd0, instr_valid0}, 64'd0);
        stepClock();
        checkOutput("t1_out", {32'd0, instr_out0}, 64'h2001000D);
        checkOutput("t1_pc", {34'd0, instr_pc0}, 64'd0);
        checkOutput("t1_valid", {63'd0, instr_valid0}, 64'd1);
        checkOutput("t1_count", {48'd0, fetch_count0}, 64'd1);
        checkOutput("t1_addr", {34'd0, rom_address0}, 64'd1);
        stepClock();
        checkOutput("t1_halted", {63'd0, halted0}, 64'd1);
        checkOutput("t1_valid_clr", {63'd0, instr_valid0}, 64'd0);

        // Redirect out of HALT refetches address 0
        redirect_valid = 1'b1; redirect_addr = 30'd0;
        stepClock();
        redirect_valid = 1'b0;
        checkOutput("t3_valid", {63'd0, instr_valid0}, 64'd0);
        checkOutput("t3_halted", {63'd0, halted0}, 64'd0);
        stepClock();
        checkOutput("t3_out", {32'd0, instr_out0}, 64'h2001000D);
        checkOutput("t3_count", {48'd0, fetch_count0}, 64'd2);

        // Stalled consumer: word held through HALT until accepted
        resetDut();
        start = 1'b1;
        stepClock();
        start = 1'b0;
        stepClock();
        checkOutput("t2_valid", {63'd0, instr_valid0}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            stepClock();
            checkOutput("t2_hold_valid", {63'd0, instr_valid0}, 64'd1);
            checkOutput("t2_hold_out", {32'd0, instr_out0}, 64'h2001000D);
            checkOutput("t2_halted", {63'd0, halted0}, 64'd1);
        end
        instr_ready = 1'b1;
        stepClock();
        checkOutput("t2_clr", {63'd0, instr_valid0}, 64'd0);
        checkOutput("t2_halted_end", {63'd0, halted0}, 64'd1);

        // Redirect while stalled with a valid buffer
        resetDut();
        start = 1'b1;
        stepClock();
        start = 1'b0;
        stepClock();
        redirect_valid = 1'b1; redirect_addr = 30'd5;
        stepClock();
        redirect_valid = 1'b0;
        checkOutput("t4_valid", {63'd0, instr_valid0}, 64'd0);
        checkOutput("t4_addr", {34'd0, rom_address0}, 64'd5);
        checkOutput("t4_count", {48'd0, fetch_count0}, 64'd1);

        // Reset during a stall, then no fetching without start
        resetDut();
        start = 1'b1;
        stepClock();
        start = 1'b0;
        stepClock();
        checkOutput("t6_pre_valid", {63'd0, instr_valid0}, 64'd1);
        reset = 1'b1;
        stepClock();
        reset = 1'b0; instr_ready = 1'b1;
        checkOutput("t6_valid", {63'd0, instr_valid0}, 64'd0);
        checkOutput("t6_out", {32'd0, instr_out0}, 64'd0);
        checkOutput("t6_count", {48'd0, fetch_count0}, 64'd0);
        for (int i = 0; i < 3; i++) stepClock();
        checkOutput("t6_idle_addr", {34'd0, rom_address0}, 64'd0);
        checkOutput("t6_idle_valid", {63'd0, instr_valid0}, 64'd0);
        checkOutput("t6_idle_count", {48'd0, fetch_count0}, 64'd0);

        // PC wrap on the instance starting at the top of the address space
        resetDut();
        instr_ready = 1'b1; start = 1'b1;
        stepClock();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stepClock();
            checkOutput("t5_pc", {34'd0, instr_pc1}, {34'd0, 30'h3FFFFFFF + 30'(i)});
            checkOutput("t5_count", {48'd0, fetch_count1}, 64'(i + 1));
        end

        // Randomized run against the behavioural model
        rom_mode = 1'b1;
        reset = 1'b1; start = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_addr = 30'd0;
        modelStep();
        stepClock();
        for (int c = 0; c < 600; c++) begin
            applyStimulus();
            modelStep();
            stepClock();
            checkOutput("rnd_valid", {63'd0, instr_valid0}, {63'd0, m_valid});
            checkOutput("rnd_out", {32'd0, instr_out0}, {32'd0, m_out});
            checkOutput("rnd_ipc", {34'd0, instr_pc0}, {34'd0, m_ipc});
            checkOutput("rnd_halted", {63'd0, halted0}, {63'd0, m_halted});
            checkOutput("rnd_count", {48'd0, fetch_count0}, {48'd0, m_cnt});
            checkOutput("rnd_addr", {34'd0, rom_address0}, {34'd0, m_pc});
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
